// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions, controller state encoding and a flag packing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   // Opcode map; 13-15 are illegal (12 is also illegal without ALU_MUL_EN)
   localparam logic [3:0] OP_PASS = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SL   = 4'd6;
   localparam logic [3:0] OP_SR   = 4'd7;
   localparam logic [3:0] OP_GT   = 4'd8;
   localparam logic [3:0] OP_LT   = 4'd9;
   localparam logic [3:0] OP_EQ   = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   // Bit positions inside the 5-bit flags vector
   localparam int FLG_Z   = 0;
   localparam int FLG_N   = 1;
   localparam int FLG_C   = 2;
   localparam int FLG_V   = 3;
   localparam int FLG_ERR = 4;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } state_t;

   function automatic logic [4:0] pack_flags(input logic err, input logic v,
                                             input logic c, input logic n,
                                             input logic z);
      logic [4:0] f;
      f          = '0;
      f[FLG_ERR] = err;
      f[FLG_V]   = v;
      f[FLG_C]   = c;
      f[FLG_N]   = n;
      f[FLG_Z]   = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency: WIDTH steps after the start edge; done/product are valid combinationally during the last step.
// Backpressure: none; the owner must not pulse start while a product is in flight.
// Ports: CLK, reset_n (async active-low, aborts any run); start/a/b load a new job;
//        done flags the final step, product is the full product in that cycle.
module alu_mul_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic               CLK,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic               busy;
   logic [SHW-1:0]     cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] step_sum;

   // Partial sum after the current step; on the last step this is the final product,
   // so the owner can capture it on the same edge that retires the job.
   assign step_sum = acc + (mplier[0] ? mcand : '0);
   assign done     = busy && (cnt == SHW'(WIDTH - 1));
   assign product  = step_sum;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         acc    <= step_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU (add/sub, bitwise, shifts, compares, optional MUL) with Z/N/C/V/ERR flags.
// Latency: 1 cycle for single-cycle ops; WIDTH cycles for MUL when built with ALU_MUL_EN.
// Backpressure: in_ready drops while an unconsumed result is held or a MUL runs; out/flags hold until out_ready.
// Ports: CLK, reset_n (async active-low); in_valid/in_ready/op/in_a/in_b request side;
//        out_valid/out_ready/out/flags result side, flags = {ERR,V,C,N,Z}.
// Build option: define ALU_MUL_EN to include the iterative multiplier (op 12); otherwise op 12 is illegal.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [4:0]       flags
);

   localparam int MSB = WIDTH - 1;

   logic             accept;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic             shift_big;
   logic [SHW-1:0]   sh_amt;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;
   logic             res_err;
   logic [4:0]       res_flags;

   assign accept = in_valid && in_ready;
   assign add_w  = {1'b0, in_a} + {1'b0, in_b};
   // Top bit of the widened difference is the borrow, i.e. a < b unsigned
   assign sub_w  = {1'b0, in_a} - {1'b0, in_b};

   // Shift amount is the whole of in_b: any bit at or above SHW means amount >= WIDTH
   assign shift_big = |in_b[WIDTH-1:SHW];
   assign sh_amt    = in_b[SHW-1:0];

   always_comb begin
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_err = 1'b0;
      case (op)
         OP_PASS: res = in_a;
         OP_ADD: begin
            res   = add_w[WIDTH-1:0];
            res_c = add_w[WIDTH];
            res_v = (in_a[MSB] == in_b[MSB]) && (add_w[MSB] != in_a[MSB]);
         end
         OP_SUB: begin
            res   = sub_w[WIDTH-1:0];
            res_c = sub_w[WIDTH];
            res_v = (in_a[MSB] != in_b[MSB]) && (sub_w[MSB] != in_a[MSB]);
         end
         OP_OR:  res = in_a | in_b;
         OP_AND: res = in_a & in_b;
         OP_XOR: res = in_a ^ in_b;
         OP_SL:  res = shift_big ? '0 : (in_a << sh_amt);
         OP_SR:  res = shift_big ? '0 : (in_a >> sh_amt);
         OP_SRA: res = shift_big ? {WIDTH{in_a[MSB]}} : $unsigned($signed(in_a) >>> sh_amt);
         OP_GT:  res = {{(WIDTH-1){1'b0}}, (in_a > in_b)};
         OP_LT:  res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
         OP_EQ:  res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
         // Illegal ops (and MUL, which never retires through this path) give 0 with ERR
         default: res_err = 1'b1;
      endcase
      res_flags = pack_flags(res_err, res_v, res_c, res[MSB], (res == '0));
   end

`ifdef ALU_MUL_EN
   state_t             state;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   mul_lo;
   logic [4:0]         mul_flags;

   assign mul_start = accept && (op == OP_MUL);
   assign mul_lo    = mul_prod[WIDTH-1:0];
   assign mul_flags = pack_flags(1'b0, 1'b0, |mul_prod[2*WIDTH-1:WIDTH], mul_lo[MSB],
                                 (mul_lo == '0));
   assign in_ready  = reset_n && (state == ST_IDLE) && (!out_valid || out_ready);

   alu_mul_seq #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_mul (
      .CLK     (CLK),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (in_a),
      .b       (in_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         out       <= '0;
         flags     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mul_start) begin
                  // Accept implies any held result is being consumed this edge
                  state     <= ST_MUL_RUN;
                  out_valid <= 1'b0;
               end else if (accept) begin
                  out       <= res;
                  flags     <= res_flags;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            ST_MUL_RUN: begin
               if (mul_done) begin
                  out       <= mul_lo;
                  flags     <= mul_flags;
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`else
   // Single implicit IDLE state: no multiplier, op 12 falls into the illegal path
   assign in_ready = reset_n && (!out_valid || out_ready);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         out       <= '0;
         flags     <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         out       <= res;
         flags     <= res_flags;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with hand-computed results for alu_pipe at WIDTH=16.
// Latency: checks 1-cycle ops and, with ALU_MUL_EN, the 16-cycle MUL.
// Backpressure: exercises held results, stalled requests and reset during a busy period.
module tb_alu_pipe;

   localparam int W = 16;

   logic         CLK = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic [4:0]   flags;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   alu_pipe #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flags     (flags)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
      int n;
      op = o; in_a = a; in_b = b; in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
   endtask

   task automatic run(input string tag, input logic [3:0] o, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] eo, input logic [4:0] ef);
      issue(o, a, b);
      chk({tag, "_out"}, 32'(out), 32'(eo));
      chk({tag, "_flags"}, 32'(flags), 32'(ef));
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
   endtask

`ifdef ALU_MUL_EN
   // Counts posedges from the accept edge until out_valid rises
   task automatic mul_lat(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eo, input logic [4:0] ef);
      int n;
      logic busy_ok;
      op = 4'd12; in_a = a; in_b = b; in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      @(posedge CLK);
      #1 in_valid = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (!out_valid && n < 40) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge CLK);
         #1;
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd16);
      chk({tag, "_busy_rdy"}, 32'(busy_ok), 32'd1);
      chk({tag, "_out"}, 32'(out), 32'(eo));
      chk({tag, "_flags"}, 32'(flags), 32'(ef));
      @(negedge CLK);
   endtask
`endif

   initial begin
      int c0;
      logic quiet;
      reset_n = 1'b0; in_valid = 1'b0; op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_in_rdy", 32'(in_ready), 32'd0);
      reset_n = 1'b1;
      #1 chk("post_rst_in_rdy", 32'(in_ready), 32'd1);
      @(negedge CLK);

      // flags = {ERR,V,C,N,Z}
      run("add_wrap",  4'd1,  16'hFFFF, 16'h0001, 16'h0000, 5'h05);
      run("add_ovf",   4'd1,  16'h7FFF, 16'h0001, 16'h8000, 5'h0A);
      run("sub_ovf",   4'd2,  16'h8000, 16'h0001, 16'h7FFF, 5'h08);
      run("sub_brw",   4'd2,  16'h0001, 16'h0002, 16'hFFFF, 5'h06);
      run("sra_big",   4'd11, 16'h8000, 16'd20,   16'hFFFF, 5'h02);
      run("sl_big",    4'd6,  16'h0001, 16'd16,   16'h0000, 5'h01);
      run("sr_4",      4'd7,  16'hF000, 16'd4,    16'h0F00, 5'h00);
      run("sl_15",     4'd6,  16'h0001, 16'd15,   16'h8000, 5'h02);
      run("sr_big",    4'd7,  16'h8000, 16'd16,   16'h0000, 5'h01);
      run("sra_2",     4'd11, 16'h4000, 16'd2,    16'h1000, 5'h00);
      run("sra_15",    4'd11, 16'h8000, 16'd15,   16'hFFFF, 5'h02);
      run("pass",      4'd0,  16'h1234, 16'hFFFF, 16'h1234, 5'h00);
      run("or",        4'd3,  16'h00F0, 16'h0F00, 16'h0FF0, 5'h00);
      run("and",       4'd4,  16'hFF00, 16'h0FF0, 16'h0F00, 5'h00);
      run("xor",       4'd5,  16'hA5A5, 16'hFFFF, 16'h5A5A, 5'h00);
      run("gt_t",      4'd8,  16'h0005, 16'h0003, 16'h0001, 5'h00);
      run("gt_unsig",  4'd8,  16'h8000, 16'h0001, 16'h0001, 5'h00);
      run("lt_f",      4'd9,  16'h0005, 16'h0003, 16'h0000, 5'h01);
      run("eq_t",      4'd10, 16'h0007, 16'h0007, 16'h0001, 5'h00);
      run("eq_f",      4'd10, 16'h0007, 16'h0008, 16'h0000, 5'h01);
      run("ill_13",    4'd13, 16'h1234, 16'h5678, 16'h0000, 5'h11);
      run("ill_14",    4'd14, 16'h1234, 16'h5678, 16'h0000, 5'h11);
      run("ill_15",    4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 5'h11);
`ifndef ALU_MUL_EN
      run("mul_off",   4'd12, 16'h0012, 16'h0034, 16'h0000, 5'h11);
`endif

      // Result consumed with no new request: out_valid clears
      @(negedge CLK);
      chk("drain_vld", 32'(out_valid), 32'd0);

      // Back-to-back throughput: 4 ops in 4 cycles
      c0 = cyc;
      issue(4'd1, 16'd1, 16'd1);
      issue(4'd1, 16'd2, 16'd2);
      issue(4'd1, 16'd3, 16'd3);
      issue(4'd1, 16'd4, 16'd4);
      chk("b2b_cycles", 32'(cyc - c0), 32'd4);
      chk("b2b_last", 32'(out), 32'h8);

      // Backpressure
      @(negedge CLK);
      out_ready = 1'b0;
      run("bp_add", 4'd1, 16'd2, 16'd3, 16'd5, 5'h00);
      chk("bp_in_rdy", 32'(in_ready), 32'd0);
      op = 4'd5; in_a = 16'h00FF; in_b = 16'h0F0F; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("bp_hold_out", 32'(out), 32'd5);
         chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_rdy", 32'(in_ready), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      chk("bp_xor_out", 32'(out), 32'h0FF0);
      chk("bp_xor_vld", 32'(out_valid), 32'd1);
      @(negedge CLK);
      chk("bp_drain_vld", 32'(out_valid), 32'd0);

`ifdef ALU_MUL_EN
      mul_lat("mul_a", 16'h0012, 16'h0034, 16'h03A8, 5'h00);
      mul_lat("mul_hi", 16'h0100, 16'h0100, 16'h0000, 5'h05);
      mul_lat("mul_ff", 16'hFFFF, 16'hFFFF, 16'h0001, 5'h04);
`endif

      // Reset while busy: result held (out=3) and, with the multiplier, a MUL in flight
      out_ready = 1'b0;
      run("pre_rst_add", 4'd1, 16'd1, 16'd2, 16'd3, 5'h00);
`ifdef ALU_MUL_EN
      out_ready = 1'b1;
      op = 4'd12; in_a = 16'h0012; in_b = 16'h0034; in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (8) @(posedge CLK);
      #1 chk("mid_mul_vld", 32'(out_valid), 32'd0);
`endif
      reset_n = 1'b0;
      #1;
      chk("arst_vld", 32'(out_valid), 32'd0);
      chk("arst_out", 32'(out), 32'd0);
      chk("arst_flags", 32'(flags), 32'd0);
      chk("arst_in_rdy", 32'(in_ready), 32'd0);
      repeat (2) @(negedge CLK);
      reset_n = 1'b1;
      out_ready = 1'b1;
      #1 chk("rel_in_rdy", 32'(in_ready), 32'd1);
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (out_valid) quiet = 1'b0;
      end
      chk("no_stale_result", 32'(quiet), 32'd1);
      run("post_rst_add", 4'd1, 16'd1, 16'd1, 16'd2, 5'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

endmodule
